// File: rtl/cla_serial_add_ctrl.sv
// Serial WIDTH-bit adder controller: one nibble per clock through a shared 4-bit CLA slice.
// Optional subtract mode (extra 'sub' port) is enabled by defining CLA_SERIAL_SUB_EN.
module cla_serial_add_ctrl #(
  parameter int WIDTH = 16,
  parameter int NIB   = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if (WIDTH < 4 || (WIDTH % 4) != 0 || NIB != WIDTH / 4) begin : g_bad_width
      $error("cla_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4; NIB must be WIDTH/4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             carry;
  logic             op_sub;
  logic             start_carry;
  logic             last;
  logic [3:0]       a_nib, b_nib, g, p, c, s_nib;
  logic             c4;

`ifdef CLA_SERIAL_SUB_EN
  logic sub_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sub_reg <= 1'b0;
    else if (state == IDLE && in_valid)
      sub_reg <= sub;
  end

  assign op_sub      = sub_reg;
  assign start_carry = sub ? 1'b1 : cin;
`else
  assign op_sub      = 1'b0;
  assign start_carry = cin;
`endif

  assign last  = (idx == IW'(NIB - 1));
  assign a_sh  = a_reg >> {idx, 2'b00};
  assign b_sh  = b_reg >> {idx, 2'b00};
  assign a_nib = a_sh[3:0];
  assign b_nib = op_sub ? ~b_sh[3:0] : b_sh[3:0];

  // 4-bit carry-look-ahead slice; only the carry between nibbles goes through 'carry'
  assign g    = a_nib & b_nib;
  assign p    = a_nib ^ b_nib;
  assign c[0] = carry;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign s_nib = p ^ c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // sum is cleared on accept, so each nibble can be OR-ed into its slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            carry <= start_carry;
            idx   <= '0;
            sum   <= '0;
          end
        end
        RUN: begin
          sum   <= sum | (WIDTH'(s_nib) << {idx, 2'b00});
          carry <= c4;
          if (last)
            cout <= c4;
          else
            idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cla_serial_add_ctrl.md
Name: cla_serial_add_ctrl

Overview:
Sequencing controller that performs WIDTH-bit additions by time-multiplexing one 4-bit carry-look-ahead adder slice. It processes one nibble per clock, least-significant nibble first, and keeps the inter-nibble carry in a register. It has a valid/ready handshake on both the operand side and the result side. It sits between a requesting datapath and the single shared 4-bit CLA slice, trading latency for area.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4. Other values are illegal: elaboration error.
NIB, WIDTH/4, derived number of nibble steps; not to be overridden.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operands a, b, cin are valid.
in_ready  output  1  controller can accept operands; high only in IDLE.
a  input  WIDTH  addend A.
b  input  WIDTH  addend B.
cin  input  1  carry into nibble 0.
out_valid  output  1  sum/cout are valid; high only in DONE.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  result a+b+cin, modulo 2^WIDTH.
cout  output  1  carry out of the most-significant nibble.
busy  output  1  high in RUN.

Behaviour:
- Reset (asynchronous, active-high):
  - state goes to IDLE; nibble index, carry register, operand registers, sum and cout all clear to 0.
  - out_valid=0, busy=0.
  - in_ready=1, because it is decoded from state IDLE and is therefore high during and after reset.
- Three states, IDLE, RUN and DONE:
  - IDLE: accept operands when in_valid & in_ready. On that edge, latch a, b and cin (cin goes into the carry register), clear the index to 0, clear sum to 0, and go to RUN. With in_valid=0, stay in IDLE.
  - RUN: each cycle, drive the CLA slice with a_reg[4i+3:4i], b_reg[4i+3:4i] and the carry register. On the edge, write the slice sum into sum[4i+3:4i], load the slice carry into the carry register, and increment the index.
    - When i==NIB-1, also load cout from the slice carry and go to DONE instead of incrementing.
    - in_valid and a/b/cin are ignored in RUN; the latched operands are used.
  - DONE: out_valid=1. Hold sum and cout stable while out_ready=0, with no limit on how long. When out_valid & out_ready, go to IDLE on the edge. out_valid drops and in_ready rises in the next cycle.
- No overlap: a new operand is never accepted in the same cycle a result is consumed. Minimum throughput is one addition per NIB+2 cycles.
- Latency: operands accepted at edge T; out_valid is high from edge T+NIB onward. With WIDTH=16, that is 4 cycles.
- Arithmetic: the nibble slice uses carry-look-ahead equations (generate = a&b, propagate = a^b, full 4-level carry expansion). The inter-nibble carry is rippled through the register only.
- Boundary conditions:
  - WIDTH=4 gives one RUN cycle.
  - The all-ones operand with cin=1 must produce sum=all-ones and cout=1.
  - Index wrap: the index never exceeds NIB-1.
  - sum holds partial results during RUN and is only guaranteed meaningful when out_valid=1.
  - Asserting rst in RUN or DONE aborts immediately. The result is discarded, no out_valid pulse occurs, and the block returns to IDLE with all registers cleared.

Optional Feature:
Macro CLA_SERIAL_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), latched with the operands on acceptance.
  - With sub=1, the controller feeds ~b nibbles to the slice and forces the initial carry to 1; the cin port is ignored. sum = a-b modulo 2^WIDTH, and cout=1 means no borrow (a>=b).
  - With sub=0, behaviour is identical to plain addition.
- Undefined: the sub port is absent and the block only adds.

Test Plan:
- WIDTH=16, a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. out_valid asserts exactly 4 cycles after the accept edge; busy is high for those 4 cycles.
- WIDTH=16, a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0. Hold out_ready=0 for 5 cycles: sum/cout/out_valid are stable, in_ready=0 throughout. After the handshake, in_ready=1 on the next cycle.
- Apply in_valid with a=0x0F0F, b=0x00F1 during RUN. The new operands are ignored and the in-flight result 0x0F0F+previous b completes. Then a=0x0F0F, b=0x00F1, cin=0 accepted in IDLE -> sum=0x1000, cout=0.
- Assert rst for 1 cycle while the index is 2 in RUN -> out_valid never rises, state is IDLE, in_ready=1, sum=0, cout=0. The next addition 0x0001+0x0001 -> 0x0002.
- WIDTH=4 build: a=0xF, b=0xF, cin=1 -> sum=0xF, cout=1 after 1 cycle. Back-to-back requests with out_ready tied high complete in 3-cycle intervals.
- With CLA_SERIAL_SUB_EN defined, WIDTH=16:
  - sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0.
  - sub=1, a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
